// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings used by the APB-to-AHB bridge and its bench.
package peripheral_ahb3_pkg;

    // Transfer type
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Transfer size
    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    // Burst type
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Slave response
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Protection bits, OR-combined into HPROT
    localparam logic [3:0] HPROT_OPCODE     = 4'b0000;
    localparam logic [3:0] HPROT_DATA       = 4'b0001;
    localparam logic [3:0] HPROT_USER       = 4'b0000;
    localparam logic [3:0] HPROT_PRIVILEGED = 4'b0010;

endpackage

// File: rtl/peripheral_apb_ahb_master_if.sv
// APB slave-side and AHB master-side signal bundle of the bridge.
// The "master" modport is the bridge itself; "slave" is its environment.
interface peripheral_apb_ahb_master_if #(
    parameter int HADDR_SIZE = 32,
    parameter int PADDR_SIZE = 32
) ();
    // APB side
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [PADDR_SIZE-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [2:0]            PPROT;
    logic [31:0]           PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;
    // AHB side
    logic [HADDR_SIZE-1:0] HADDR;
    logic [31:0]           HWDATA;
    logic [31:0]           HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, HRDATA, HREADY, HRESP,
        output PRDATA, PREADY, PSLVERR, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT,
               HTRANS, HMASTLOCK
    );

    modport slave (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, HRDATA, HREADY, HRESP,
        input  PRDATA, PREADY, PSLVERR, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT,
               HTRANS, HMASTLOCK
    );
endinterface

// File: rtl/peripheral_pstrb2hsize.sv
// Maps an APB write-strobe pattern onto an AHB transfer size and byte offset.
// Only naturally aligned byte, halfword and word patterns are legal.
module peripheral_pstrb2hsize
    import peripheral_ahb3_pkg::*;
(
    input  logic [3:0] PSTRB,
    output logic [2:0] HSIZE,
    output logic [1:0] offset,
    output logic       illegal
);

    // Strobe pattern decode table
    always_comb begin
        HSIZE   = HSIZE_WORD;
        offset  = 2'd0;
        illegal = 1'b0;
        case (PSTRB)
            4'b1111: begin HSIZE = HSIZE_WORD;  offset = 2'd0; end
            4'b0011: begin HSIZE = HSIZE_HWORD; offset = 2'd0; end
            4'b1100: begin HSIZE = HSIZE_HWORD; offset = 2'd2; end
            4'b0001: begin HSIZE = HSIZE_BYTE;  offset = 2'd0; end
            4'b0010: begin HSIZE = HSIZE_BYTE;  offset = 2'd1; end
            4'b0100: begin HSIZE = HSIZE_BYTE;  offset = 2'd2; end
            4'b1000: begin HSIZE = HSIZE_BYTE;  offset = 2'd3; end
            default: begin HSIZE = HSIZE_WORD;  offset = 2'd0; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/peripheral_apb_ahb_master.sv
// APB slave to AHB3-Lite master bridge: one single transfer per APB access.
// Every bus output is a flop; HBURST/HMASTLOCK are tied constants.
module peripheral_apb_ahb_master
    import peripheral_ahb3_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 32
) (
    input logic                         HCLK,
    input logic                         HRESETn,
    peripheral_apb_ahb_master_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]            state_r;
    logic [1:0]            htrans_r;
    logic [HADDR_SIZE-1:0] haddr_r;
    logic [HDATA_SIZE-1:0] hwdata_r;
    logic [HDATA_SIZE-1:0] wdata_r;
    logic                  hwrite_r;
    logic [2:0]            hsize_r;
    logic [3:0]            hprot_r;
    logic [HDATA_SIZE-1:0] prdata_r;
    logic                  pready_r;
    logic                  pslverr_r;
    logic                  abort_r;

    logic [2:0]            dec_hsize_s;
    logic [1:0]            dec_offset_s;
    logic                  dec_illegal_s;
    logic [2:0]            req_hsize_s;
    logic [1:0]            req_offset_s;
    logic                  req_illegal_s;
    logic [HADDR_SIZE-1:0] req_haddr_s;
    logic [3:0]            req_hprot_s;
    logic                  setup_s;
    logic                  unused_s;

    peripheral_pstrb2hsize u_pstrb2hsize (
        .PSTRB   (bus.PSTRB),
        .HSIZE   (dec_hsize_s),
        .offset  (dec_offset_s),
        .illegal (dec_illegal_s)
    );

    // Reads are always full-word; writes take the strobe decode
    always_comb begin
        req_hsize_s   = HSIZE_WORD;
        req_offset_s  = 2'd0;
        req_illegal_s = 1'b0;
        if (bus.PWRITE) begin
            req_hsize_s   = dec_hsize_s;
            req_offset_s  = dec_offset_s;
            req_illegal_s = dec_illegal_s;
        end else begin
            req_hsize_s   = HSIZE_WORD;
            req_offset_s  = 2'd0;
            req_illegal_s = 1'b0;
        end
    end

    // Request address/protection derived from the APB setup phase
    always_comb begin
        req_haddr_s      = HADDR_SIZE'(bus.PADDR);
        req_haddr_s[1:0] = req_offset_s;
        req_hprot_s      = (bus.PPROT[2] ? HPROT_OPCODE : HPROT_DATA) |
                           (bus.PPROT[0] ? HPROT_PRIVILEGED : HPROT_USER);
    end

    assign setup_s  = bus.PSEL & ~bus.PENABLE;
    assign unused_s = bus.PPROT[1];

    // Bridge sequencer: setup -> AHB address phase -> AHB data phase -> APB response
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r   <= ST_IDLE;
            htrans_r  <= HTRANS_IDLE;
            haddr_r   <= '0;
            hwdata_r  <= '0;
            wdata_r   <= '0;
            hwrite_r  <= 1'b0;
            hsize_r   <= HSIZE_WORD;
            hprot_r   <= 4'b0000;
            prdata_r  <= '0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    abort_r   <= 1'b0;
                    if (setup_s && req_illegal_s) begin
                        state_r   <= ST_RESP;
                        pready_r  <= 1'b1;
                        pslverr_r <= 1'b1;
                    end else if (setup_s) begin
                        state_r  <= ST_ADDR;
                        htrans_r <= HTRANS_NONSEQ;
                        haddr_r  <= req_haddr_s;
                        hwrite_r <= bus.PWRITE;
                        hsize_r  <= req_hsize_s;
                        hprot_r  <= req_hprot_s;
                        wdata_r  <= bus.PWDATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    // A deselect is remembered; the AHB transfer still runs out
                    abort_r <= abort_r | ~bus.PSEL;
                    if (bus.HREADY) begin
                        state_r  <= ST_DATA;
                        htrans_r <= HTRANS_IDLE;
                        hwdata_r <= wdata_r;
                    end else begin
                        state_r <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    abort_r <= abort_r | ~bus.PSEL;
                    if (bus.HREADY && (abort_r || !bus.PSEL)) begin
                        state_r <= ST_IDLE;
                    end else if (bus.HREADY) begin
                        state_r   <= ST_RESP;
                        pready_r  <= 1'b1;
                        pslverr_r <= (bus.HRESP == HRESP_ERROR);
                        if (!hwrite_r) begin
                            prdata_r <= bus.HRDATA;
                        end else begin
                            prdata_r <= prdata_r;
                        end
                    end else begin
                        // Also covers the first cycle of a two-cycle ERROR
                        state_r <= ST_DATA;
                    end
                end
                ST_RESP: begin
                    state_r   <= ST_IDLE;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    htrans_r  <= HTRANS_IDLE;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HTRANS    = htrans_r;
    assign bus.HADDR     = haddr_r;
    assign bus.HWDATA    = hwdata_r;
    assign bus.HWRITE    = hwrite_r;
    assign bus.HSIZE     = hsize_r;
    assign bus.HPROT     = hprot_r;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.PRDATA    = prdata_r;
    assign bus.PREADY    = pready_r;
    assign bus.PSLVERR   = pslverr_r;

endmodule

// File: tb/tb_peripheral_apb_ahb_master.sv
// Bench for the APB-to-AHB bridge: a per-cycle expectation queue built from a
// transaction-level model, one negedge compare process, plus literal checks.
module tb_peripheral_apb_ahb_master;
    import peripheral_ahb3_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    peripheral_apb_ahb_master_if #(.HADDR_SIZE(32), .PADDR_SIZE(32)) bus ();

    peripheral_apb_ahb_master #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.master)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  htrans;
        bit          chk_addr;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic        hwrite;
        logic [3:0]  hprot;
        bit          chk_wdata;
        logic [31:0] hwdata;
        logic        pready;
        logic        pslverr;
        bit          chk_rdata;
        logic [31:0] prdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cmp;
    int errors = 0;
    int checks = 0;

    // observations recorded by the compare process for literal checks
    int          obs_ready_cyc;
    int          obs_ready_cnt = 0;
    int          obs_nonseq_cnt = 0;
    logic        obs_pslverr;
    logic [31:0] obs_haddr, obs_hwdata, obs_prdata;
    logic [2:0]  obs_hsize;
    logic [3:0]  obs_hprot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t idle_exp(input int c);
        exp_t e;
        e.cyc = c; e.htrans = HTRANS_IDLE;
        e.chk_addr = 1'b0; e.haddr = 32'd0; e.hsize = 3'd0; e.hwrite = 1'b0; e.hprot = 4'd0;
        e.chk_wdata = 1'b0; e.hwdata = 32'd0;
        e.pready = 1'b0; e.pslverr = 1'b0;
        e.chk_rdata = 1'b0; e.prdata = 32'd0;
        return e;
    endfunction

    // Behavioural strobe model: counts and locates set bits
    function automatic void model_decode(input logic wr, input logic [3:0] strb,
                                         output logic [2:0] size, output logic [1:0] off,
                                         output logic ill);
        int ones;
        int low;
        ones = $countones(strb);
        low = 0;
        for (int i = 3; i >= 0; i--) if (strb[i]) low = i;
        size = 3'd2; off = 2'd0; ill = 1'b0;
        if (!wr) return;
        if (ones == 4) begin size = 3'd2; off = 2'd0; end
        else if (ones == 2 && (low == 0 || low == 2) && strb[low+1]) begin size = 3'd1; off = 2'(low); end
        else if (ones == 1) begin size = 3'd0; off = 2'(low); end
        else ill = 1'b1;
    endfunction

    // compare process: one expectation per cycle, sampled mid-cycle
    always @(negedge HCLK) begin
        if (exp_q.size() > 0) begin
            e_cmp = exp_q.pop_front();
            check("htrans",    32'(bus.HTRANS),    32'(e_cmp.htrans));
            check("pready",    32'(bus.PREADY),    32'(e_cmp.pready));
            check("pslverr",   32'(bus.PSLVERR),   32'(e_cmp.pslverr));
            check("hburst",    32'(bus.HBURST),    32'(3'b000));
            check("hmastlock", 32'(bus.HMASTLOCK), 32'(1'b0));
            if (e_cmp.chk_addr) begin
                check("haddr",  bus.HADDR,          e_cmp.haddr);
                check("hsize",  32'(bus.HSIZE),     32'(e_cmp.hsize));
                check("hwrite", 32'(bus.HWRITE),    32'(e_cmp.hwrite));
                check("hprot",  32'(bus.HPROT),     32'(e_cmp.hprot));
                obs_haddr = bus.HADDR; obs_hsize = bus.HSIZE; obs_hprot = bus.HPROT;
            end
            if (e_cmp.chk_wdata) begin
                check("hwdata", bus.HWDATA, e_cmp.hwdata);
                obs_hwdata = bus.HWDATA;
            end
            if (e_cmp.chk_rdata) begin
                check("prdata", bus.PRDATA, e_cmp.prdata);
                obs_prdata = bus.PRDATA;
            end
            if (bus.PREADY) begin
                obs_ready_cyc = e_cmp.cyc;
                obs_pslverr = bus.PSLVERR;
                obs_ready_cnt++;
            end
            if (bus.HTRANS == HTRANS_NONSEQ) obs_nonseq_cnt++;
        end
    end

    task automatic step(input exp_t e);
        @(posedge HCLK);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic drive_idle();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'd0;
        bus.PWDATA = 32'd0; bus.PSTRB = 4'd0; bus.PPROT = 3'd0;
        bus.HRDATA = 32'd0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    endtask

    task automatic clear_obs();
        obs_ready_cyc = -1; obs_pslverr = 1'bx;
        obs_haddr = 32'hx; obs_hwdata = 32'hx; obs_prdata = 32'hx;
        obs_hsize = 3'bx; obs_hprot = 4'bx;
    endtask

    // One APB access with a planned AHB slave behaviour; drop_at=0 means no deselect
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, input logic [2:0] prot,
                            input int wa, input int wd_in, input logic err,
                            input logic [31:0] rdata, input int drop_at);
        exp_t e;
        logic [2:0] size;
        logic [1:0] off;
        logic ill;
        logic psel;
        int c;
        int wd;
        wd = (err && wd_in == 0) ? 1 : wd_in;
        model_decode(wr, strb, size, off, ill);
        step(idle_exp(0));
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr;
        bus.PWDATA = wdata; bus.PSTRB = strb; bus.PPROT = prot;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        if (ill) begin
            e = idle_exp(1); e.pready = 1'b1; e.pslverr = 1'b1;
            step(e);
            bus.PENABLE = 1'b1;
            return;
        end
        c = 0;
        for (int i = 0; i <= wa; i++) begin
            c++;
            e = idle_exp(c); e.htrans = HTRANS_NONSEQ; e.chk_addr = 1'b1;
            e.haddr = {addr[31:2], off}; e.hsize = size; e.hwrite = wr;
            e.hprot = {2'b00, prot[0], ~prot[2]};
            step(e);
            psel = !(drop_at != 0 && c >= drop_at);
            bus.PSEL = psel; bus.PENABLE = psel;
            bus.HREADY = (i == wa); bus.HRESP = 1'b0;
        end
        for (int j = 0; j <= wd; j++) begin
            c++;
            e = idle_exp(c); e.chk_wdata = wr; e.hwdata = wdata;
            step(e);
            psel = !(drop_at != 0 && c >= drop_at);
            bus.PSEL = psel; bus.PENABLE = psel;
            bus.HREADY = (j == wd);
            bus.HRESP = err && (j >= wd - 1);
            bus.HRDATA = (j == wd) ? rdata : $urandom;
        end
        c++;
        e = idle_exp(c);
        if (drop_at == 0) begin
            e.pready = 1'b1; e.pslverr = err; e.chk_rdata = !wr; e.prdata = rdata;
        end
        step(e);
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    endtask

    initial begin
        int rc0, nc0;
        HRESETn = 1'b1;
        drive_idle();
        clear_obs();
        #1 HRESETn = 1'b0;
        #3;
        check("rst_htrans",  32'(bus.HTRANS),  32'(2'b00));
        check("rst_haddr",   bus.HADDR,        32'd0);
        check("rst_hwdata",  bus.HWDATA,       32'd0);
        check("rst_hwrite",  32'(bus.HWRITE),  32'(1'b0));
        check("rst_hsize",   32'(bus.HSIZE),   32'(3'b010));
        check("rst_hprot",   32'(bus.HPROT),   32'(4'b0000));
        check("rst_prdata",  bus.PRDATA,       32'd0);
        check("rst_pready",  32'(bus.PREADY),  32'(1'b0));
        check("rst_pslverr", 32'(bus.PSLVERR), 32'(1'b0));
        repeat (2) step(idle_exp(-1));
        HRESETn = 1'b1;
        step(idle_exp(-1));

        // zero-wait word write
        clear_obs();
        apb_xfer(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 3'b000, 0, 0, 1'b0, 32'd0, 0);
        step(idle_exp(-1)); drive_idle();
        check("w_haddr", obs_haddr, 32'h100);
        check("w_hsize", 32'(obs_hsize), 32'(3'b010));
        check("w_hprot", 32'(obs_hprot), 32'(4'b0001));
        check("w_hwdata", obs_hwdata, 32'hDEADBEEF);
        check("w_latency", 32'(obs_ready_cyc), 32'd3);
        check("w_pslverr", 32'(obs_pslverr), 32'(1'b0));

        // read with two data-phase wait states, privileged opcode protection
        clear_obs();
        apb_xfer(1'b0, 32'h204, 4'b0000, 32'd0, 3'b101, 0, 2, 1'b0, 32'h12345678, 0);
        step(idle_exp(-1)); drive_idle();
        check("r_prdata", obs_prdata, 32'h12345678);
        check("r_latency", 32'(obs_ready_cyc), 32'd5);
        check("r_hprot", 32'(obs_hprot), 32'(4'b0010));

        // byte write at lane 2
        clear_obs();
        apb_xfer(1'b1, 32'h300, 4'b0100, 32'h00AA0000, 3'b000, 0, 0, 1'b0, 32'd0, 0);
        step(idle_exp(-1)); drive_idle();
        check("b_haddr", obs_haddr, 32'h302);
        check("b_hsize", 32'(obs_hsize), 32'(3'b000));

        // illegal strobe: immediate error, no AHB transfer
        clear_obs();
        nc0 = obs_nonseq_cnt;
        apb_xfer(1'b1, 32'h300, 4'b0101, 32'h1, 3'b000, 0, 0, 1'b0, 32'd0, 0);
        step(idle_exp(-1)); drive_idle();
        check("ill_latency", 32'(obs_ready_cyc), 32'd1);
        check("ill_pslverr", 32'(obs_pslverr), 32'(1'b1));
        check("ill_nonseq", 32'(obs_nonseq_cnt - nc0), 32'd0);

        // two-cycle ERROR response on a read
        clear_obs();
        rc0 = obs_ready_cnt;
        apb_xfer(1'b0, 32'h400, 4'b0000, 32'd0, 3'b000, 1, 1, 1'b1, 32'hCAFE0001, 0);
        step(idle_exp(-1)); drive_idle();
        step(idle_exp(-1));
        check("err_pulses", 32'(obs_ready_cnt - rc0), 32'd1);
        check("err_pslverr", 32'(obs_pslverr), 32'(1'b1));

        // deselect mid-transfer: no response
        rc0 = obs_ready_cnt;
        apb_xfer(1'b1, 32'h500, 4'b1111, 32'h55, 3'b000, 1, 1, 1'b0, 32'd0, 2);
        step(idle_exp(-1)); drive_idle();
        check("abort_pulses", 32'(obs_ready_cnt - rc0), 32'd0);

        // reset while in the data phase
        begin
            exp_t e;
            step(idle_exp(0));
            bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h40;
            bus.PWDATA = 32'hA5A5A5A5; bus.PSTRB = 4'b1111;
            e = idle_exp(1); e.htrans = HTRANS_NONSEQ;
            step(e);
            bus.PENABLE = 1'b1; bus.HREADY = 1'b1;
            step(idle_exp(2));
            bus.HREADY = 1'b0;
            #1 HRESETn = 1'b0;
            #1;
            check("mid_rst_htrans", 32'(bus.HTRANS), 32'(2'b00));
            check("mid_rst_pready", 32'(bus.PREADY), 32'(1'b0));
            check("mid_rst_haddr",  bus.HADDR,       32'd0);
            check("mid_rst_hwdata", bus.HWDATA,      32'd0);
            drive_idle();
            step(idle_exp(-1));
            HRESETn = 1'b1;
            step(idle_exp(-1));
            clear_obs();
            apb_xfer(1'b1, 32'h44, 4'b1111, 32'h0BADF00D, 3'b000, 0, 0, 1'b0, 32'd0, 0);
            step(idle_exp(-1)); drive_idle();
            check("post_rst_latency", 32'(obs_ready_cyc), 32'd3);
            check("post_rst_hwdata", obs_hwdata, 32'h0BADF00D);
        end

        // randomized traffic, including back-to-back and deselects
        for (int n = 0; n < 150; n++) begin
            logic wr, err;
            logic [3:0] strb;
            int wa, wd, drop, gap;
            wr = 1'($urandom_range(0, 1));
            strb = 4'($urandom_range(0, 15));
            wa = $urandom_range(0, 2);
            wd = $urandom_range(0, 3);
            err = ($urandom_range(0, 5) == 0);
            drop = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2 + wa + wd) : 0;
            if (err && wd == 0) wd = 1;
            if (drop > 2 + wa + wd) drop = 2 + wa + wd;
            apb_xfer(wr, $urandom, strb, $urandom, 3'($urandom_range(0, 7)),
                     wa, wd, err, $urandom, drop);
            gap = $urandom_range(0, 2);
            if (drop != 0 && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                step(idle_exp(-1));
                drive_idle();
            end
        end

        step(idle_exp(-1));
        drive_idle();
        @(negedge HCLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
